// File: rtl/reflet_vga_wb_rect_fill_if.sv
// Wishbone classic bus bundle between the rectangle-fill initiator and the
// VGA framebuffer slave.
interface reflet_vga_wb_rect_fill_if #(
    parameter int bus_size = 32
);
    logic [bus_size-1:0] wb_adr_o;
    logic [bus_size-1:0] wb_dat_o;
    logic [bus_size-1:0] wb_dat_i;
    logic                wb_we_o;
    logic                wb_cyc_o;
    logic                wb_stb_o;
    logic                wb_ack_i;
    logic                wb_err_i;
    logic [3:0]          wb_tag_o;

    modport master (
        output wb_adr_o, wb_dat_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_tag_o,
        input  wb_dat_i, wb_ack_i, wb_err_i
    );

    modport slave (
        input  wb_adr_o, wb_dat_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_tag_o,
        output wb_dat_i, wb_ack_i, wb_err_i
    );
endinterface

// File: rtl/reflet_vga_wb_rect_fill.sv
// Wishbone initiator that paints an axis-aligned rectangle by writing the
// framebuffer's Y, X and colour registers pixel by pixel (row-major).
module reflet_vga_wb_rect_fill #(
    parameter int                  bus_size    = 32,
    parameter int                  coord_width = 16,
    parameter int                  color_width = 24,
    parameter logic [bus_size-1:0] x_addr      = 32'h7000_0000,
    parameter logic [bus_size-1:0] y_addr      = 32'h7000_0004,
    parameter logic [bus_size-1:0] color_addr  = 32'h7000_0008,
    parameter int                  timeout     = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [coord_width-1:0] x0,
    input  logic [coord_width-1:0] y0,
    input  logic [coord_width-1:0] x1,
    input  logic [coord_width-1:0] y1,
    input  logic [color_width-1:0] color_i,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    reflet_vga_wb_rect_fill_if.master wb
);

    localparam int TW = (timeout > 1) ? $clog2(timeout) : 1;
    localparam logic [TW-1:0] WAIT_LAST = TW'((timeout > 0) ? timeout - 1 : 0);

    typedef enum logic [2:0] {IDLE, WR_Y, WR_X, WR_C, FIN} state_t;

    state_t                 state, state_n;
    logic [coord_width-1:0] cur_x, cur_y, cx_n, cy_n;
    logic [coord_width-1:0] lx0, lx1, ly1;
    logic [color_width-1:0] col_q, col_n;
    logic [TW-1:0]          wait_cnt, wait_n;
    logic                   load, error_n;
    logic                   xfer_ok, xfer_err, tmo, abort;
    logic                   stb_n, done_n;
    logic [bus_size-1:0]    adr_n, dat_n;
    logic                   unused_dat;

    assign wb.wb_tag_o = 4'd0;
    assign unused_dat  = ^wb.wb_dat_i;

    // Bus responses only count while our strobe is up; err beats ack.
    assign xfer_err = wb.wb_stb_o & wb.wb_err_i;
    assign xfer_ok  = wb.wb_stb_o & wb.wb_ack_i & ~wb.wb_err_i;
    assign tmo      = (timeout > 0) && wb.wb_stb_o && !wb.wb_ack_i && !wb.wb_err_i
                      && (wait_cnt == WAIT_LAST);
    assign abort    = xfer_err | tmo;

    always_comb begin
        state_n = state;
        cx_n    = cur_x;
        cy_n    = cur_y;
        load    = 1'b0;
        error_n = error;
        wait_n  = '0;
        if (wb.wb_stb_o && !wb.wb_ack_i && !wb.wb_err_i)
            wait_n = wait_cnt + 1'b1;

        case (state)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    error_n = 1'b0;
                    if ((x1 < x0) || (y1 < y0)) begin
                        state_n = FIN;
                    end else begin
                        state_n = WR_Y;
                        cx_n    = x0;
                        cy_n    = y0;
                    end
                end
            end
            WR_Y, WR_X, WR_C: begin
                if (abort) begin
                    state_n = FIN;
                    error_n = 1'b1;
                end else if (xfer_ok) begin
                    if (state == WR_Y) begin
                        state_n = WR_X;
                    end else if (state == WR_X) begin
                        state_n = WR_C;
                    end else if (cur_x < lx1) begin
                        // Increment only when strictly below the limit so an
                        // all-ones corner never wraps.
                        cx_n    = cur_x + 1'b1;
                        state_n = WR_X;
                    end else if (cur_y < ly1) begin
                        cx_n    = lx0;
                        cy_n    = cur_y + 1'b1;
                        state_n = WR_Y;
                    end else begin
                        state_n = FIN;
                    end
                end
            end
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase

        col_n = load ? color_i : col_q;

        // Bus outputs are registered: derive them from the next state.
        stb_n = 1'b0;
        adr_n = '0;
        dat_n = '0;
        case (state_n)
            WR_Y: begin
                stb_n = 1'b1;
                adr_n = y_addr;
                dat_n = bus_size'(cy_n);
            end
            WR_X: begin
                stb_n = 1'b1;
                adr_n = x_addr;
                dat_n = bus_size'(cx_n);
            end
            WR_C: begin
                stb_n = 1'b1;
                adr_n = color_addr;
                dat_n = bus_size'(col_n);
            end
            default: ;
        endcase
        done_n = (state_n == FIN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            error       <= 1'b0;
            done        <= 1'b0;
            busy        <= 1'b0;
            wait_cnt    <= '0;
            wb.wb_stb_o <= 1'b0;
            wb.wb_cyc_o <= 1'b0;
            wb.wb_we_o  <= 1'b0;
            wb.wb_adr_o <= '0;
            wb.wb_dat_o <= '0;
        end else begin
            state       <= state_n;
            error       <= error_n;
            done        <= done_n;
            busy        <= stb_n;
            wait_cnt    <= wait_n;
            wb.wb_stb_o <= stb_n;
            wb.wb_cyc_o <= stb_n;
            wb.wb_we_o  <= stb_n;
            wb.wb_adr_o <= adr_n;
            wb.wb_dat_o <= dat_n;
        end
    end

    // Command and scan registers carry data only; the FSM qualifies them.
    always_ff @(posedge clk) begin
        if (load) begin
            lx0 <= x0;
            lx1 <= x1;
            ly1 <= y1;
        end
        cur_x <= cx_n;
        cur_y <= cy_n;
        col_q <= col_n;
    end

endmodule
